// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks x0..x(NUM_REGS-1) through one read port
// and streams each value out over a valid/ready interface.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int SKIP_X0  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
  // Compared against the last index, so NUM_REGS == 2**ADDR_W needs no carry bit.
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t state, state_next;
  logic   handshake;
  logic   last_beat;

  assign handshake = out_valid && out_ready;
  assign last_beat = (out_index == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: if (handshake) state_next = last_beat ? DONE : LOAD;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (abort) begin
      rf_addr   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) rf_addr <= FIRST_IDX;
        LOAD: begin
          // Only point where the register file is sampled; later writes
          // do not disturb the beat being held.
          out_data  <= rf_data;
          out_index <= rf_addr;
          out_valid <= 1'b1;
        end
        SEND: if (handshake) begin
          out_valid <= 1'b0;
          if (!last_beat) rf_addr <= rf_addr + ADDR_W'(1);
        end
        DONE: rf_addr <= '0;
        default: rf_addr <= '0;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == SEND);
  assign done = (state == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected beats are queued at start
// and compared in order as the consumer accepts them.
module tb_reg_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic start_s = 1'b0, abort_s = 1'b0, ready_s = 1'b1;

  logic [ADDR_W-1:0] rf_addr, out_index, rf_addr_s, out_index_s;
  logic [DATA_W-1:0] rf_data, out_data, rf_data_s, out_data_s;
  logic out_valid, busy, done, out_valid_s, busy_s, done_s;

  function automatic logic [DATA_W-1:0] reg_value(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : 32'h1000_0000 + DATA_W'(a);
  endfunction

  assign rf_data   = reg_value(rf_addr);
  assign rf_data_s = reg_value(rf_addr_s);

  reg_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKIP_X0(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
  );

  reg_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKIP_X0(1)) u_dut_skip (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
    .rf_addr(rf_addr_s), .rf_data(rf_data_s),
    .out_valid(out_valid_s), .out_ready(ready_s),
    .out_data(out_data_s), .out_index(out_index_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  beat_t q[$];
  beat_t q_s[$];
  int beats = 0, beats_s = 0, dones = 0, dones_s = 0;
  logic prev_hold = 1'b0, prev_kill = 1'b0;
  logic [ADDR_W-1:0] prev_idx = '0;
  logic [DATA_W-1:0] prev_data = '0;

  // Inputs change just after posedge, so values seen here are what the next edge uses.
  always @(negedge clk) begin
    beat_t e;
    if (prev_hold && !prev_kill) begin
      check("hold_valid", out_valid, 1);
      check("hold_index", out_index, prev_idx);
      check("hold_data", out_data, prev_data);
    end
    prev_hold = out_valid && !out_ready;
    prev_kill = abort || reset;
    prev_idx  = out_index;
    prev_data = out_data;
    if (out_valid && out_ready) begin
      beats++;
      check("beat_queued", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("beat_index", out_index, e.idx);
        check("beat_data", out_data, e.data);
      end
    end
    if (out_valid_s && ready_s) begin
      beats_s++;
      check("skip_beat_queued", q_s.size() != 0, 1);
      if (q_s.size() != 0) begin
        e = q_s.pop_front();
        check("skip_beat_index", out_index_s, e.idx);
        check("skip_beat_data", out_data_s, e.data);
      end
    end
    if (done)   dones++;
    if (done_s) dones_s++;
  end

  task automatic push_dump(input int first, input bit skip_dut);
    beat_t e;
    for (int i = first; i < NUM_REGS; i++) begin
      e.idx  = ADDR_W'(i);
      e.data = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
      if (skip_dut) q_s.push_back(e);
      else          q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the main DUT and count edges until done is seen.
  task automatic run_dump(input bit toggle, input int repulse, input int budget, output int lat);
    lat = 0;
    start = 1'b1;
    while (lat < budget) begin
      step();
      lat++;
      start = (lat == repulse);
      if (toggle) out_ready = lat[0];
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_addr"}, rf_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0, d0, cyc;

    reset = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    check("reset_skip_rf_addr", rf_addr_s, 0);
    reset = 1'b0;
    step();

    // Full dump, consumer always ready.
    push_dump(0, 0);
    b0 = beats; d0 = dones; out_ready = 1'b1;
    run_dump(0, 0, 200, lat);
    check("full_latency", lat, 65);
    repeat (3) step();
    check("full_beats", beats - b0, 32);
    check("full_dones", dones - d0, 1);
    check("full_q_empty", q.size(), 0);
    check("full_busy_after", busy, 0);
    check("full_rf_addr_after", rf_addr, 0);

    // Back-pressure: ready alternates low/high.
    push_dump(0, 0);
    b0 = beats; d0 = dones; out_ready = 1'b0;
    run_dump(1, 0, 400, lat);
    out_ready = 1'b1;
    repeat (3) step();
    check("toggle_beats", beats - b0, 32);
    check("toggle_dones", dones - d0, 1);
    check("toggle_q_empty", q.size(), 0);

    // SKIP_X0 instance.
    push_dump(1, 1);
    b0 = beats_s; d0 = dones_s; lat = 0;
    start_s = 1'b1;
    while (lat < 200) begin
      step();
      lat++;
      start_s = 1'b0;
      if (done_s) break;
    end
    check("skip_latency", lat, 63);
    repeat (3) step();
    check("skip_beats", beats_s - b0, 31);
    check("skip_dones", dones_s - d0, 1);
    check("skip_q_empty", q_s.size(), 0);

    // Abort while index 7 is held with ready low.
    push_dump(0, 0);
    b0 = beats; d0 = dones; out_ready = 1'b1; start = 1'b1; cyc = 0;
    while (cyc < 200) begin
      step();
      cyc++;
      start = 1'b0;
      if (out_valid && out_index == 7) break;
    end
    check("abort_reached_idx", out_index, 7);
    out_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rf_addr", rf_addr, 0);
    repeat (5) step();
    check("abort_no_done", dones - d0, 0);
    check("abort_beats", beats - b0, 7);
    check("abort_q_left", q.size(), 25);
    q.delete();
    push_dump(0, 0);
    b0 = beats; out_ready = 1'b1;
    run_dump(0, 0, 200, lat);
    check("restart_latency", lat, 65);
    repeat (3) step();
    check("restart_beats", beats - b0, 32);
    check("restart_q_empty", q.size(), 0);

    // start re-pulsed mid-dump and during the DONE cycle.
    push_dump(0, 0);
    b0 = beats; d0 = dones;
    run_dump(0, 20, 200, lat);
    check("repulse_latency", lat, 65);
    start = 1'b1;
    step();
    start = 1'b0;
    check("repulse_busy_after_done", busy, 0);
    check("repulse_rf_addr", rf_addr, 0);
    repeat (4) step();
    check("repulse_busy_idle", busy, 0);
    check("repulse_beats", beats - b0, 32);
    check("repulse_dones", dones - d0, 1);
    check("repulse_q_empty", q.size(), 0);

    // Reset while index 20 is held.
    push_dump(0, 0);
    b0 = beats; out_ready = 1'b1; start = 1'b1; cyc = 0;
    while (cyc < 200) begin
      step();
      cyc++;
      start = 1'b0;
      if (out_valid && out_index == 20) break;
    end
    check("reset_reached_idx", out_index, 20);
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("midreset");
    check("midreset_beats", beats - b0, 20);
    check("midreset_q_left", q.size(), 12);
    q.delete();
    push_dump(0, 0);
    b0 = beats; d0 = dones; out_ready = 1'b1;
    run_dump(0, 0, 200, lat);
    check("post_reset_latency", lat, 65);
    repeat (3) step();
    check("post_reset_beats", beats - b0, 32);
    check("post_reset_dones", dones - d0, 1);
    check("post_reset_q_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side companion to the core register file: walks every architectural register through one register-file read port and streams each value out over a valid/ready interface.
- Used after halt (or on debugger request) to dump x0..x31 to the testbench, UART bridge or trace logger.
- Owns only the read address it drives; it never writes the register file.

Parameters:
- NUM_REGS, 32, number of registers to dump (index range 0..NUM_REGS-1).
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.
- SKIP_X0, 0, when 1 the dump starts at index 1 (x0 is not emitted).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns the block to IDLE from any state.
- rf_addr  output  ADDR_W  register-file read address (registered).
- rf_data  input  DATA_W  combinational register-file read data for rf_addr (x0 reads 0).
- out_valid  output  1  out_data/out_index hold a valid beat.
- out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both 1.
- out_data  output  DATA_W  register value.
- out_index  output  ADDR_W  register number of out_data.
- busy  output  1  high in LOAD and SEND.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: state IDLE, rf_addr = 0, out_valid = 0, out_data = 0, out_index = 0, busy = 0, done = 0. Reset overrides start and abort.
- IDLE:
  - start = 1 -> LOAD. rf_addr is set to the first index (0, or 1 when SKIP_X0 = 1).
  - start = 0 -> stay in IDLE.
- LOAD (one cycle):
  - rf_data is captured into out_data and rf_addr into out_index.
  - out_valid is set to 1, and the state moves to SEND.
- SEND:
  - out_valid, out_data and out_index stay stable until the handshake.
  - Handshake with index < NUM_REGS-1: out_valid -> 0, rf_addr increments by 1, state -> LOAD.
  - Handshake with index = NUM_REGS-1: out_valid -> 0, state -> DONE.
- DONE (one cycle): done = 1, then IDLE. rf_addr returns to 0.
- Latency:
  - start sampled at edge k gives out_valid = 1 after edge k+1.
  - Minimum of 2 cycles per beat.
  - Full dump with out_ready tied high: 2*NUM_REGS + 1 cycles from start to the done pulse (2*(NUM_REGS-1) + 1 when SKIP_X0 = 1).
- start while busy or in DONE: ignored, with no restart and no queuing.
- abort = 1 in any state: after the next edge the state is IDLE, out_valid = 0, busy = 0, done = 0 and rf_addr = 0.
- abort in the same cycle as a SEND handshake: that beat counts as delivered to the consumer, the block still goes to IDLE, and no done pulse is produced.
- abort and start in the same cycle in IDLE: abort wins and the block stays in IDLE.
- Index counter:
  - Saturates at the last index and never wraps past NUM_REGS-1.
  - Width is ADDR_W with no carry-out, so for NUM_REGS = 2**ADDR_W the compare is against the last index, not against NUM_REGS.
- rf_data is sampled only in LOAD. Register-file writes that land while in SEND are not reflected in the beat currently held.
- busy = 1 exactly when the state is LOAD or SEND.

Test Plan:
- Reset, then preload xN = 0x1000_0000 + N; pulse start with out_ready = 1 -> 32 beats, index 0..31, data 0 then 0x1000_0001..0x1000_001F; done pulses at start + 65 cycles.
- out_ready toggles 1-low/1-high during the dump -> each beat is held stable while out_ready = 0; no beat is duplicated or dropped; all 32 indices arrive in order.
- SKIP_X0 = 1 -> first beat index 1, last beat index 31, 31 beats total, done at start + 63 cycles.
- abort asserted in SEND at index 7 with out_ready = 0 -> out_valid = 0 the next cycle, no done pulse, busy = 0; a following start restarts at index 0.
- start re-pulsed mid-dump and in the DONE cycle -> ignored; beat count stays 32 and exactly one done pulse is produced.
- reset asserted in SEND at index 20 -> all outputs return to their reset values after the next edge; a subsequent start produces a complete dump from index 0.
